// File: rtl/seq_mul_hs_if.sv
// Operand/result handshake bundle for seq_mul_hs.
// is_signed exists only when MUL_SIGNED_EN is defined.
interface seq_mul_hs_if #(
    parameter int WA = 4,
    parameter int WB = 4
);
    logic [WA-1:0]    A;
    logic [WB-1:0]    B;
    logic             in_valid;
    logic             in_ready;
    logic [WA+WB-1:0] Y;
    logic             rdy;
    logic             out_ready;
`ifdef MUL_SIGNED_EN
    logic             is_signed;

    modport master (
        output A, B, in_valid, out_ready, is_signed,
        input  in_ready, Y, rdy
    );

    modport slave (
        input  A, B, in_valid, out_ready, is_signed,
        output in_ready, Y, rdy
    );
`else
    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, Y, rdy
    );

    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, Y, rdy
    );
`endif
endinterface

// File: rtl/seq_mul_hs.sv
// Iterative shift-add multiplier, WB run cycles, held result.
// Define MUL_SIGNED_EN to add the two's-complement is_signed mode.
module seq_mul_hs #(
    parameter int WA = 4,
    parameter int WB = 4
) (
    input  logic         clk,
    input  logic         reset,
    seq_mul_hs_if.slave  bus
);
    localparam int W  = WA + WB;
    localparam int CW = $clog2(WB + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [WB-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic [W-1:0]  y_q, y_d;
    logic          in_ready;
    logic          last;
    logic [W-1:0]  pp;
    logic [W-1:0]  a_ext;
    logic          sub;
`ifdef MUL_SIGNED_EN
    logic          sgn_q, sgn_d;
`endif

    assign in_ready     = reset && (state_q == IDLE);
    assign bus.in_ready = in_ready;
    assign bus.rdy      = rdy_q;
    assign bus.Y        = y_q;

    assign last = (cnt_q == CW'(WB - 1));
    assign pp   = b_q[0] ? a_q : '0;

`ifdef MUL_SIGNED_EN
    // Sign-extend A in signed mode; B's MSB carries negative weight
    assign a_ext = bus.is_signed
                 ? {{WB{bus.A[WA-1]}}, bus.A}
                 : {{WB{1'b0}}, bus.A};
    assign sub   = sgn_q && last;
`else
    assign a_ext = {{WB{1'b0}}, bus.A};
    assign sub   = 1'b0;
`endif

    // Next-state: capture, shift-add per bit of B, hold result
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        y_d     = y_q;
`ifdef MUL_SIGNED_EN
        sgn_d   = sgn_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    state_d = RUN;
                    a_d     = a_ext;
                    b_d     = bus.B;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                    sgn_d   = bus.is_signed;
`endif
                end
            end
            RUN: begin
                acc_d = sub ? acc_q - pp : acc_q + pp;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    y_d     = acc_d;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    rdy_d   = 1'b0;
                    y_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rdy_d   = 1'b0;
                y_d     = '0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            y_q     <= '0;
`ifdef MUL_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            y_q     <= y_d;
`ifdef MUL_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end
endmodule
